stream_mux_rr: RTL

//  Parametrised N-channel, W-bit streaming multiplexer; successor to the 4:1 select-line mux.
//  Per-channel valid/ready/last inputs, one registered valid/ready/last output.
//  Two modes: FIXED (external select, legacy-compatible) and ROUND-ROBIN (fair arbitration).
//  A grant is held for a whole packet, up to the beat with last=1. Sits between producers and a shared sink.

---
 rtl/stream_mux_pkg.sv | 12 +
 rtl/rr_arbiter.sv | 37 +++
 rtl/stream_mux_rr.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/stream_mux_pkg.sv
// Shared definitions for the round-robin / fixed-select stream multiplexer.
package stream_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Increment a channel index, wrapping at n back to zero.
  function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: rotate requests so the slot after ptr
// comes first, priority-encode, then map the winning offset back to a channel.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int SEL_W = 2
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  int unsigned     start;
  int unsigned     off;
  logic [N_CH-1:0] rot;

  always_comb begin
    start = next_idx(32'(ptr), N_CH);
    rot   = '0;
    for (int j = 0; j < N_CH; j++) begin
      rot[j] = req[SEL_W'((start + j) % N_CH)];
    end

    gnt_valid = 1'b0;
    off       = 0;
    for (int j = 0; j < N_CH; j++) begin
      if (rot[j] && !gnt_valid) begin
        gnt_valid = 1'b1;
        off       = j;
      end
    end
    gnt_idx = SEL_W'((start + off) % N_CH);
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel streaming mux with fixed-select or round-robin arbitration,
// packet-level grant locking and a single registered output stage.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int W     = 8,
  parameter int SEL_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic [SEL_W-1:0]  sel,
  input  logic [N_CH-1:0]   in_valid,
  output logic [N_CH-1:0]   in_ready,
  input  logic [N_CH*W-1:0] in_data,
  input  logic [N_CH-1:0]   in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      out_data,
  output logic              out_last,
  output logic [SEL_W-1:0]  out_ch,
  output logic              locked
);

  logic             locked_q,    locked_d;
  logic [SEL_W-1:0] lock_ch_q,   lock_ch_d;
  logic             lock_mode_q, lock_mode_d;
  logic [SEL_W-1:0] rr_ptr_q,    rr_ptr_d;
  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     out_data_q,  out_data_d;
  logic             out_last_q,  out_last_d;
  logic [SEL_W-1:0] out_ch_q,    out_ch_d;

  logic             load;
  logic             mode_eff;
  logic [SEL_W-1:0] arb_idx;
  logic             arb_valid;
  logic             sel_in_range;
  logic [SEL_W-1:0] grant_idx;
  logic             grant_en;
  logic             grant_valid;
  logic             accept;
  logic             g_valid;
  logic [W-1:0]     g_data;
  logic             g_last;

  rr_arbiter #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_arb (
    .req       (in_valid),
    .ptr       (rr_ptr_q),
    .gnt_idx   (arb_idx),
    .gnt_valid (arb_valid)
  );

  assign load     = !out_valid_q || out_ready;
  assign mode_eff = locked_q ? lock_mode_q : mode;

  // A held grant overrides mode/sel until the packet's last beat goes through.
  always_comb begin
    sel_in_range = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (sel == SEL_W'(i)) sel_in_range = 1'b1;
    end

    if (locked_q) begin
      grant_idx = lock_ch_q;
      grant_en  = 1'b1;
    end else if (mode == MODE_RR) begin
      grant_idx = arb_idx;
      grant_en  = arb_valid;
    end else begin
      grant_idx = sel;
      grant_en  = sel_in_range;
    end
  end

  always_comb begin
    g_valid = 1'b0;
    g_data  = '0;
    g_last  = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant_idx == SEL_W'(i)) begin
        g_valid = in_valid[i];
        g_data  = in_data[i*W +: W];
        g_last  = in_last[i];
      end
    end
    grant_valid = grant_en && g_valid;
    accept      = load && grant_valid;
  end

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      in_ready[i] = load && grant_valid && (grant_idx == SEL_W'(i));
    end
  end

  always_comb begin
    locked_d    = locked_q;
    lock_ch_d   = lock_ch_q;
    lock_mode_d = lock_mode_q;
    rr_ptr_d    = rr_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_ch_d    = out_ch_q;

    if (load) out_valid_d = accept;

    if (accept) begin
      out_data_d = g_data;
      out_last_d = g_last;
      out_ch_d   = grant_idx;
      if (g_last) begin
        locked_d = 1'b0;
        if (mode_eff == MODE_RR) rr_ptr_d = grant_idx;
      end else begin
        locked_d    = 1'b1;
        lock_ch_d   = grant_idx;
        lock_mode_d = mode_eff;
      end
    end
  end

  // Pointer resets to the last channel so channel 0 wins the first RR scan.
  always_ff @(posedge clk) begin
    if (rst) begin
      locked_q    <= 1'b0;
      lock_ch_q   <= '0;
      lock_mode_q <= MODE_FIXED;
      rr_ptr_q    <= SEL_W'(N_CH - 1);
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_ch_q    <= '0;
    end else begin
      locked_q    <= locked_d;
      lock_ch_q   <= lock_ch_d;
      lock_mode_q <= lock_mode_d;
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_ch_q    <= out_ch_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_ch    = out_ch_q;
  assign locked    = locked_q;

endmodule
